// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : i2c_pkg                                                    |
// | Brief   : Shared widths, default table depth and sequencer state     |
// |           encoding for the I2C init-sequencer slice.                 |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package i2c_pkg;

  localparam int I2C_ADDR_W       = 7;
  localparam int I2C_DATA_W       = 8;
  localparam int NUM_CMDS_DEFAULT = 6;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD      = 4'd1,
    ST_ISSUE     = 4'd2,
    ST_WAIT_BUSY = 4'd3,
    ST_WAIT_DONE = 4'd4,
    ST_DELAY     = 4'd5,
    ST_NEXT      = 4'd6,
    ST_FINISH    = 4'd7,
    ST_FAIL      = 4'd8
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_init_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : i2c_init_rom                                               |
// | Brief   : Combinational command table (camera power-up list).        |
// |           Each entry is {device address, data byte, post-write       |
// |           delay}. Unused indices read back as all-zero.              |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module i2c_init_rom
  import i2c_pkg::*;
#(
  parameter int DELAY_W = 16
) (
  input  logic [7:0]            cmd_idx,
  output logic [I2C_ADDR_W-1:0] cmd_addr,
  output logic [I2C_DATA_W-1:0] cmd_data,
  output logic [DELAY_W-1:0]    cmd_delay
);

  // Table lookup: index selects one write and its settle time
  always_comb begin
    cmd_addr  = '0;
    cmd_data  = '0;
    cmd_delay = '0;
    case (cmd_idx)
      8'd0: begin cmd_addr = 7'h58; cmd_data = 8'h01; cmd_delay = DELAY_W'(0);   end
      8'd1: begin cmd_addr = 7'h58; cmd_data = 8'h90; cmd_delay = DELAY_W'(4);   end
      8'd2: begin cmd_addr = 7'h21; cmd_data = 8'hC0; cmd_delay = DELAY_W'(0);   end
      8'd3: begin cmd_addr = 7'h21; cmd_data = 8'h0A; cmd_delay = DELAY_W'(100); end
      8'd4: begin cmd_addr = 7'h3C; cmd_data = 8'h12; cmd_delay = DELAY_W'(0);   end
      8'd5: begin cmd_addr = 7'h3C; cmd_data = 8'h80; cmd_delay = DELAY_W'(8);   end
      default: begin
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_delay = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : i2c_init_sequencer                                         |
// | Brief   : Walks an external command table and issues one single-     |
// |           write transaction per entry to an I2C master, with per-    |
// |           entry settle delay and handshake timeouts.                 |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int NUM_CMDS = NUM_CMDS_DEFAULT,
  parameter int DELAY_W  = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  output logic [7:0]            cmd_idx,
  input  logic [I2C_ADDR_W-1:0] cmd_addr,
  input  logic [I2C_DATA_W-1:0] cmd_data,
  input  logic [DELAY_W-1:0]    cmd_delay,
  output logic                  master_start,
  output logic [I2C_ADDR_W-1:0] master_addr,
  output logic [I2C_DATA_W-1:0] master_data,
  input  logic                  master_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int                 TIMER_W     = $clog2(TIMEOUT) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [7:0]         LAST_IDX    = 8'(NUM_CMDS - 1);
  localparam logic [DELAY_W-1:0] DELAY_ONE   = DELAY_W'(1);

  seq_state_e             state_q;
  logic [7:0]             idx_q;
  logic                   start_q;
  logic [I2C_ADDR_W-1:0]  addr_q;
  logic [I2C_DATA_W-1:0]  data_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic [TIMER_W-1:0]     timer_q;
  logic [TIMER_W-1:0]     timer_d;
  logic [DELAY_W-1:0]     delay_q;

  // Incremented wait timer; a wait state aborts once this reaches the limit
  assign timer_d = timer_q + TIMER_ONE;

  // Sequencer FSM; every output is a flop so the master sees clean controls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      start_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      timer_q <= '0;
      delay_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          addr_q  <= cmd_addr;
          data_q  <= cmd_data;
          delay_q <= cmd_delay;
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // Only launch into an idle master; no timeout while it stays busy
          if (master_ready) begin
            start_q <= 1'b1;
            timer_q <= '0;
            state_q <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          start_q <= 1'b0;
          if (!master_ready) begin
            timer_q <= '0;
            state_q <= ST_WAIT_DONE;
          end else begin
            timer_q <= timer_d;
            if (timer_d == TIMER_LIMIT) begin
              state_q <= ST_FAIL;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (master_ready) begin
            state_q <= (delay_q != '0) ? ST_DELAY : ST_NEXT;
          end else begin
            timer_q <= timer_d;
            if (timer_d == TIMER_LIMIT) begin
              state_q <= ST_FAIL;
            end
          end
        end
        ST_DELAY: begin
          // One cycle here per unit of delay, leaving on the count of one
          delay_q <= delay_q - DELAY_ONE;
          if (delay_q == DELAY_ONE) begin
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
            state_q <= ST_FINISH;
          end else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= ST_LOAD;
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_FAIL: begin
          // idx_q is left pointing at the entry that stalled
          busy_q  <= 1'b0;
          error_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_idx      = idx_q;
  assign master_start = start_q;
  assign master_addr  = addr_q;
  assign master_data  = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_i2c_init_sequencer                                      |
// | Brief   : Scoreboard bench: command table + behavioural I2C master   |
// |           around the init sequencer.                                 |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_i2c_init_sequencer;
  import i2c_pkg::*;

  localparam int NUM_CMDS = 3;
  localparam int DELAY_W  = 16;
  localparam int TIMEOUT  = 16;

  localparam logic [6:0] T_ADDR  [NUM_CMDS] = '{7'h58, 7'h58, 7'h21};
  localparam logic [7:0] T_DATA  [NUM_CMDS] = '{8'h01, 8'h90, 8'hC0};
  localparam int         T_DELAY [NUM_CMDS] = '{0, 4, 0};

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  go = 1'b0;
  logic [7:0]            cmd_idx;
  logic [I2C_ADDR_W-1:0] cmd_addr;
  logic [I2C_DATA_W-1:0] cmd_data;
  logic [DELAY_W-1:0]    cmd_delay;
  logic                  master_start;
  logic [I2C_ADDR_W-1:0] master_addr;
  logic [I2C_DATA_W-1:0] master_data;
  logic                  master_ready;
  logic                  busy;
  logic                  done;
  logic                  error;

  i2c_init_rom #(.DELAY_W(DELAY_W)) u_rom (
    .cmd_idx   (cmd_idx),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_delay (cmd_delay)
  );

  i2c_init_sequencer #(
    .NUM_CMDS (NUM_CMDS),
    .DELAY_W  (DELAY_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .cmd_idx      (cmd_idx),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_delay    (cmd_delay),
    .master_start (master_start),
    .master_addr  (master_addr),
    .master_data  (master_data),
    .master_ready (master_ready),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard of expected writes; gap = cycles from master ready rising
  // (previous write) to this start pulse, -1 when not checked
  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
    int         gap;
  } exp_t;
  exp_t sb[$];

  // Behavioural master controls
  logic m_ready = 1'b1;
  logic m_hold = 1'b0;
  logic m_nodrop = 1'b0;
  logic m_clear = 1'b0;
  int   stuck_idx = -1;
  logic stuck = 1'b0;
  int   phase = 0;
  int   busy_left = 0;
  int   rise_cyc = 0;
  int   start_cyc = 0;
  int   nstarts = 0;

  assign master_ready = m_ready & ~m_hold;

  // Master model: drop ready the cycle after start, stay busy, then return
  always @(negedge clk) begin
    if (!reset || m_clear) begin
      m_ready = 1'b1;
      phase   = 0;
      stuck   = 1'b0;
    end else begin
      case (phase)
        0: begin
          if (master_start) begin
            exp_t e;
            check("start_while_ready", master_ready, 1'b1);
            check("sb_has_entry", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("master_addr", master_addr, e.a);
              check("master_data", master_data, e.d);
              if (e.gap >= 0) check("start_gap", cyc - rise_cyc, e.gap);
            end
            nstarts   = nstarts + 1;
            start_cyc = cyc;
            if (stuck_idx == int'(cmd_idx)) stuck = 1'b1;
            if (!m_nodrop) phase = 1;
          end
        end
        1: begin
          check("start_one_cycle", master_start, 1'b0);
          m_ready   = 1'b0;
          busy_left = 3;
          phase     = 2;
        end
        default: begin
          if (!stuck) begin
            if (busy_left == 0) begin
              m_ready  = 1'b1;
              rise_cyc = cyc;
              phase    = 0;
            end else begin
              busy_left = busy_left - 1;
            end
          end
        end
      endcase
    end
  end

  task automatic pulse_go(input bit accept);
    @(negedge clk);
    go = 1'b1;
    if (accept) begin
      for (int i = 0; i < NUM_CMDS; i++) begin
        exp_t e;
        e.a   = T_ADDR[i];
        e.d   = T_DATA[i];
        e.gap = (i == 0) ? -1 : 4 + T_DELAY[i-1];
        sb.push_back(e);
      end
    end
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    check("run_ended_in_budget", done || error, 1'b1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (nstarts < target && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    check("start_seen_in_budget", nstarts >= target, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int rel;

    // Reset state
    #12;
    check("rst_cmd_idx", cmd_idx, 8'd0);
    check("rst_start", master_start, 1'b0);
    check("rst_addr", master_addr, 7'd0);
    check("rst_data", master_data, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: happy path
    n0 = nstarts;
    pulse_go(1);
    check("busy_after_go", busy, 1'b1);
    wait_end(200);
    check("t1_starts", nstarts - n0, 3);
    check("t1_done", done, 1'b1);
    check("t1_busy", busy, 1'b0);
    check("t1_error", error, 1'b0);
    check("t1_sb_drained", sb.size(), 0);

    // 2: ready gating
    m_hold = 1'b1;
    n0 = nstarts;
    pulse_go(1);
    repeat (20) @(negedge clk);
    check("t2_no_start_while_busy_master", nstarts - n0, 0);
    m_hold = 1'b0;
    rel = cyc;
    wait_starts(n0 + 1, 10);
    check("t2_start_after_ready", start_cyc - rel, 1);
    wait_end(200);
    check("t2_done", done, 1'b1);

    // 3: busy timeout (master never drops ready)
    m_nodrop = 1'b1;
    n0 = nstarts;
    pulse_go(1);
    wait_starts(n0 + 1, 10);
    wait_end(100);
    check("t3_error_latency", cyc - start_cyc, 16);
    check("t3_error", error, 1'b1);
    check("t3_busy", busy, 1'b0);
    check("t3_done", done, 1'b0);
    check("t3_cmd_idx", cmd_idx, 8'd0);
    m_nodrop = 1'b0;
    sb.delete();

    // 4: done timeout on entry 1
    stuck_idx = 1;
    n0 = nstarts;
    pulse_go(1);
    check("t4_error_cleared", error, 1'b0);
    wait_end(200);
    check("t4_error", error, 1'b1);
    check("t4_done", done, 1'b0);
    check("t4_cmd_idx", cmd_idx, 8'd1);
    repeat (10) @(negedge clk);
    check("t4_starts", nstarts - n0, 2);
    stuck_idx = -1;
    m_clear = 1'b1;
    @(negedge clk);
    m_clear = 1'b0;
    sb.delete();

    // 5: re-trigger ignored mid-run, rerun after done
    n0 = nstarts;
    pulse_go(1);
    wait_starts(n0 + 1, 10);
    pulse_go(0);
    wait_end(200);
    check("t5_starts", nstarts - n0, 3);
    check("t5_done", done, 1'b1);
    repeat (3) @(negedge clk);
    n0 = nstarts;
    pulse_go(1);
    check("t5_done_cleared", done, 1'b0);
    check("t5_busy_again", busy, 1'b1);
    wait_end(200);
    check("t5_rerun_starts", nstarts - n0, 3);
    check("t5_done_again", done, 1'b1);
    check("t5_sb_drained", sb.size(), 0);

    // 6: reset during WAIT_DONE of entry 1
    n0 = nstarts;
    pulse_go(1);
    wait_starts(n0 + 2, 100);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_start", master_start, 1'b0);
    check("t6_cmd_idx", cmd_idx, 8'd0);
    check("t6_addr", master_addr, 7'd0);
    check("t6_data", master_data, 8'd0);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_error", error, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n0 = nstarts;
    repeat (30) @(negedge clk);
    check("t6_no_start_after_reset", nstarts - n0, 0);
    check("t6_idle_busy", busy, 1'b0);
    sb.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Sequences the single-write I2C master through an ordered list of register writes, e.g. the camera init list at power-up.
- Reads one command per step from an external command table: 7-bit device address, 8-bit data byte, post-write delay.
- Drives the master's start/addr/data inputs and tracks its ready output.
- Reports busy/done/error to the top level.

Parameters:
- NUM_CMDS, 6, number of table entries executed per run (1..256).
- DELAY_W, 16, width of per-command post-write delay in clk cycles.
- TIMEOUT, 1024, max cycles allowed in each master wait state before error.

Ports:
- clk  input  1  system clock; same clock as the I2C master.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- go  input  1  one-cycle pulse that starts a run; ignored while busy=1.
- cmd_idx  output  8  table index currently addressed.
- cmd_addr  input  7  device address at cmd_idx (combinational table read).
- cmd_data  input  8  data byte at cmd_idx.
- cmd_delay  input  DELAY_W  idle cycles to wait after this write completes.
- master_start  output  1  start pulse to the I2C master.
- master_addr  output  7  registered address to the master.
- master_data  output  8  registered data to the master.
- master_ready  input  1  master ready (high when idle or stopping).
- busy  output  1  run in progress.
- done  output  1  sticky: last run completed all NUM_CMDS writes.
- error  output  1  sticky: last run aborted on timeout.

Behaviour:
- Reset (async assert, sync release): state=IDLE; cmd_idx=0; master_start=0; master_addr=0; master_data=0; busy=0; done=0; error=0; internal timer=0; delay counter=0.
- All outputs are registered.
- FSM states: IDLE, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE, DELAY, NEXT, FINISH, FAIL.
- IDLE: on go=1, set cmd_idx=0, busy=1, done=0, error=0, then go to LOAD.
- LOAD: latch master_addr=cmd_addr, master_data=cmd_data, delay counter=cmd_delay, then go to ISSUE.
- ISSUE: wait for master_ready=1. Then pulse master_start=1 for exactly one cycle, clear timer, go to WAIT_BUSY.
- WAIT_BUSY:
  - master_start=0.
  - master_ready=0 -> clear timer, go to WAIT_DONE.
  - Otherwise timer++; timer reaching TIMEOUT-1 -> FAIL.
  - The master drops ready one or two cycles after the start pulse.
- WAIT_DONE:
  - master_ready=1 -> go to DELAY if delay counter!=0, else NEXT.
  - Otherwise timer++; timeout -> FAIL.
- DELAY: decrement each cycle; reaching 1 -> NEXT. A delay of D adds exactly D cycles.
- NEXT: cmd_idx==NUM_CMDS-1 -> FINISH; else cmd_idx++ and go to LOAD.
- FINISH: busy=0, done=1, go to IDLE.
- FAIL:
  - busy=0, error=1, go to IDLE.
  - cmd_idx holds the failing index until the next go.
- done and error are mutually exclusive and stay sticky until the next accepted go.
- go while busy=1 has no effect. go arriving in the same cycle FINISH/FAIL is entered is ignored; it is accepted only in IDLE.
- master_start is never asserted while master_ready=0. It is never asserted twice for one command.
- Reset mid-run aborts immediately. master_start drops asynchronously, so the master sees no further start. The run is not resumed.
- Index arithmetic is 8-bit and never wraps past NUM_CMDS-1.
- Timer width is clog2(TIMEOUT)+1.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding constants for this FSM;
  - I2C_ADDR_W=7 and I2C_DATA_W=8;
  - the default NUM_CMDS.
- Natural sub-module: i2c_init_rom. It is a combinational case table mapping cmd_idx to {cmd_addr, cmd_data, cmd_delay} and is instantiated beside the sequencer at top level. It is kept outside so the sequencer is reusable with other tables.

Test Plan:
1. Single-run happy path: NUM_CMDS=3, table {(0x58,0x01,0),(0x58,0x90,4),(0x21,0xC0,0)}, master behavioural model. Pulse go -> three start pulses with addr/data matching each entry in order, 4 idle cycles after the second write, then done=1, busy=0, error=0.
2. Ready gating: hold master_ready=0 for 20 cycles after go -> master_start stays 0 throughout. Start is pulsed one cycle after ready rises.
3. Busy timeout: TIMEOUT=16, master model never drops ready -> error=1 and busy=0 exactly 16 cycles after the start pulse; cmd_idx=0; done=0.
4. Done timeout: ready drops but never returns on entry 1 -> error=1; cmd_idx=1; no further start pulses.
5. Re-trigger: go pulsed mid-run is ignored (start count stays 3). A second go after done clears done, reruns all 3 writes and sets done again.
6. Reset mid-run: assert reset during WAIT_DONE of entry 1 -> all outputs zero asynchronously. After release no start pulse occurs until go.
